// File: rtl/plb_assoc_lookup_stage_pkg.sv
// Shared types for the PLB lookup stage: walker transaction format,
// PLB entry/refill records and permission bit constants.
package mpt_pkg;

    localparam int MPT_SDID_W     = 6;
    localparam int MPT_PPN_W      = 44;
    localparam int MPT_PAGE_OFS_W = 12;
    localparam int MPT_SPA_W      = MPT_PPN_W + MPT_PAGE_OFS_W;
    localparam int MPT_PERM_W     = 3;

    // Permission bits, ordered {x,w,r}
    localparam logic [MPT_PERM_W-1:0] PLB_PERM_R = 3'b001;
    localparam logic [MPT_PERM_W-1:0] PLB_PERM_W = 3'b010;
    localparam logic [MPT_PERM_W-1:0] PLB_PERM_X = 3'b100;

    typedef enum logic [1:0] {
        NO_ERROR  = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_RSVD  = 2'd3
    } mptw_format_error_e;

    typedef enum logic [1:0] {
        MPT_WALKING_START = 2'd0,
        MPT_WALKING_L2    = 2'd1,
        MPT_WALKING_L1    = 2'd2,
        MPT_WALKING_SKIP  = 2'd3
    } mptw_walking_e;

    typedef struct packed {
        logic                  valid;
        logic [MPT_SDID_W-1:0] sdid;
        logic [MPT_SPA_W-1:0]  spa;
        logic [MPT_PERM_W-1:0] access;
        mptw_format_error_e    format_error;
        mptw_walking_e         walking;
        logic                  completed;
        logic                  plb_hit;
        logic [31:0]           mpte;
        logic [15:0]           mpte_ptr;
    } mptw_transaction_t;

    localparam int MPTW_TXN_W = $bits(mptw_transaction_t);

    typedef struct packed {
        logic                  valid;
        logic [MPT_SDID_W-1:0] sdid;
        logic [MPT_PPN_W-1:0]  ppn;
        logic [MPT_PERM_W-1:0] perm;
    } plb_entry_t;

    typedef struct packed {
        logic [MPT_SDID_W-1:0] sdid;
        logic [MPT_PPN_W-1:0]  ppn;
        logic [MPT_PERM_W-1:0] perm;
    } plb_refill_t;

    // Every requested access bit must be granted by the entry
    function automatic logic perm_ok(input logic [MPT_PERM_W-1:0] access,
                                     input logic [MPT_PERM_W-1:0] perm);
        return (access & ~perm) == '0;
    endfunction

endpackage

// File: rtl/plb_assoc_lookup_stage_tag_array.sv
// Fully-associative PLB storage: parallel tag+perm match for lookups,
// refill placement (in-place update, lowest free slot, round-robin victim)
// and flush-all / flush-by-SDID invalidation.
module plb_tag_array
    import mpt_pkg::*;
#(
    parameter int PLB_ENTRIES = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [MPT_SDID_W-1:0] i_lk_sdid,
    input  logic [MPT_PPN_W-1:0]  i_lk_ppn,
    input  logic [MPT_PERM_W-1:0] i_lk_access,
    output logic                  o_hit,
    input  logic                  i_refill_valid,
    input  plb_refill_t           i_refill,
    input  logic                  i_flush,
    input  logic                  i_flush_sdid_valid,
    input  logic [MPT_SDID_W-1:0] i_flush_sdid
);

    localparam int IDX_W = $clog2(PLB_ENTRIES);

    plb_entry_t       r_entries [PLB_ENTRIES];
    logic [IDX_W-1:0] r_victim;

    logic             w_tag_match;
    logic [IDX_W-1:0] w_tag_idx;
    logic             w_free;
    logic [IDX_W-1:0] w_free_idx;

    // Lookup against current (pre-refill) contents; perm shortfall is a miss
    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < PLB_ENTRIES; i++) begin
            if (r_entries[i].valid && r_entries[i].sdid == i_lk_sdid &&
                r_entries[i].ppn == i_lk_ppn &&
                perm_ok(i_lk_access, r_entries[i].perm))
                o_hit = 1'b1;
        end
    end

    // Refill target search; descending scan so the lowest index wins
    always_comb begin
        w_tag_match = 1'b0;
        w_tag_idx   = '0;
        w_free      = 1'b0;
        w_free_idx  = '0;
        for (int i = PLB_ENTRIES - 1; i >= 0; i--) begin
            if (r_entries[i].valid && r_entries[i].sdid == i_refill.sdid &&
                r_entries[i].ppn == i_refill.ppn) begin
                w_tag_match = 1'b1;
                w_tag_idx   = IDX_W'(i);
            end
            if (!r_entries[i].valid) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Entry update: flush beats refill; victim pointer moves only on eviction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PLB_ENTRIES; i++) r_entries[i].valid <= 1'b0;
            r_victim <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < PLB_ENTRIES; i++) begin
                if (!i_flush_sdid_valid || r_entries[i].sdid == i_flush_sdid)
                    r_entries[i].valid <= 1'b0;
            end
            if (!i_flush_sdid_valid) r_victim <= '0;
        end else if (i_refill_valid) begin
            if (w_tag_match) begin
                r_entries[w_tag_idx].perm <= i_refill.perm;
            end else if (w_free) begin
                r_entries[w_free_idx] <= '{valid: 1'b1, sdid: i_refill.sdid,
                                           ppn: i_refill.ppn, perm: i_refill.perm};
            end else begin
                r_entries[r_victim] <= '{valid: 1'b1, sdid: i_refill.sdid,
                                         ppn: i_refill.ppn, perm: i_refill.perm};
                r_victim <= r_victim + 1'b1;
            end
        end
    end

endmodule

// File: rtl/plb_assoc_lookup_stage.sv
// Head of the MPT walker pipeline: looks the transaction up in a local
// fully-associative PLB; hits complete (walking=SKIP), misses go on to the walk.
// Optional hit/miss statistics are built when PLB_STATS_EN is defined.
// The slave/master buses carry exactly one packed mptw_transaction_t.
module plb_assoc_lookup_stage
    import mpt_pkg::*;
#(
    parameter int PIPELINE_SLAVE_DATA_WIDTH  = MPTW_TXN_W,
    parameter int PIPELINE_MASTER_DATA_WIDTH = MPTW_TXN_W,
    parameter int PLB_ENTRIES                = 8,
    parameter int SDID_WIDTH                 = MPT_SDID_W,
    parameter int PPN_WIDTH                  = MPT_PPN_W,
    parameter int PAGE_OFFSET_WIDTH          = MPT_PAGE_OFS_W,
    parameter int PERM_WIDTH                 = MPT_PERM_W
`ifdef PLB_STATS_EN
    , parameter int STAT_WIDTH               = 32
`endif
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  stage_slave_valid,
    output logic                                  stage_slave_ready,
    input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
    output logic                                  stage_master_valid,
    input  logic                                  stage_master_ready,
    output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
    input  logic                                  refill_valid_i,
    input  logic [SDID_WIDTH-1:0]                 refill_sdid_i,
    input  logic [PPN_WIDTH-1:0]                  refill_ppn_i,
    input  logic [PERM_WIDTH-1:0]                 refill_perm_i,
    input  logic                                  flush_i,
    input  logic                                  flush_sdid_valid_i,
    input  logic [SDID_WIDTH-1:0]                 flush_sdid_i
`ifdef PLB_STATS_EN
    , output logic [STAT_WIDTH-1:0]               stat_hits_o
    , output logic [STAT_WIDTH-1:0]               stat_misses_o
`endif
);

    mptw_transaction_t w_in;
    mptw_transaction_t w_out;
    mptw_transaction_t r_data;
    logic              r_valid;
    logic              w_accept;
    logic              w_lookup_en;
    logic              w_tag_hit;
    logic              w_hit;
    plb_refill_t       w_refill;

    assign w_in               = stage_slave_data;
    assign stage_master_data  = r_data;
    assign stage_master_valid = r_valid;
    assign stage_slave_ready  = !flush_i && (!r_valid || stage_master_ready);
    assign w_accept           = stage_slave_valid && stage_slave_ready;
    assign w_lookup_en        = w_in.valid && (w_in.format_error == NO_ERROR);
    assign w_hit              = w_lookup_en && w_tag_hit;
    assign w_refill           = '{sdid: refill_sdid_i, ppn: refill_ppn_i, perm: refill_perm_i};

    plb_tag_array #(
        .PLB_ENTRIES (PLB_ENTRIES)
    ) u_tags (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .i_lk_sdid          (w_in.sdid),
        .i_lk_ppn           (w_in.spa[PAGE_OFFSET_WIDTH +: PPN_WIDTH]),
        .i_lk_access        (w_in.access),
        .o_hit              (w_tag_hit),
        .i_refill_valid     (refill_valid_i),
        .i_refill           (w_refill),
        .i_flush            (flush_i),
        .i_flush_sdid_valid (flush_sdid_valid_i),
        .i_flush_sdid       (flush_sdid_i)
    );

    // Field rewrite: hits and malformed transactions skip the walk
    always_comb begin
        w_out           = w_in;
        w_out.completed = w_hit;
        w_out.plb_hit   = w_hit;
        w_out.mpte      = '0;
        w_out.mpte_ptr  = '0;
        if (w_in.format_error != NO_ERROR || w_hit) w_out.walking = MPT_WALKING_SKIP;
    end

    // Single output register; holds while downstream stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_out;
        end else if (stage_master_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef PLB_STATS_EN
    // Saturating counters over accepted, lookup-eligible transactions
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_hits_o   <= '0;
            stat_misses_o <= '0;
        end else if (w_accept && w_lookup_en) begin
            if (w_hit && !(&stat_hits_o))       stat_hits_o   <= stat_hits_o + 1'b1;
            if (!w_hit && !(&stat_misses_o))    stat_misses_o <= stat_misses_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_plb_assoc_lookup_stage.sv
// Bench for plb_assoc_lookup_stage: table-driven lookups plus hand sequences
// for eviction, flush, backpressure and reset; outputs checked via a scoreboard.
module tb_plb_assoc_lookup_stage;
    import mpt_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i;
    logic              s_valid, s_ready, m_valid, m_ready;
    mptw_transaction_t s_data, m_data;
    logic              refill_valid, flush, flush_sv;
    logic [5:0]        refill_sdid, flush_sdid;
    logic [43:0]       refill_ppn;
    logic [2:0]        refill_perm;
`ifdef PLB_STATS_EN
    logic [31:0]       stat_hits, stat_misses;
`endif

    int total = 0;
    int bad   = 0;
    mptw_transaction_t exp_q[$];

    plb_assoc_lookup_stage dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .stage_slave_valid  (s_valid),
        .stage_slave_ready  (s_ready),
        .stage_slave_data   (s_data),
        .stage_master_valid (m_valid),
        .stage_master_ready (m_ready),
        .stage_master_data  (m_data),
        .refill_valid_i     (refill_valid),
        .refill_sdid_i      (refill_sdid),
        .refill_ppn_i       (refill_ppn),
        .refill_perm_i      (refill_perm),
        .flush_i            (flush),
        .flush_sdid_valid_i (flush_sv),
        .flush_sdid_i       (flush_sdid)
`ifdef PLB_STATS_EN
        , .stat_hits_o      (stat_hits)
        , .stat_misses_o    (stat_misses)
`endif
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic mptw_transaction_t mk(input logic [5:0] sd, input logic [55:0] spa,
                                             input logic [2:0] acc);
        mptw_transaction_t t;
        t              = '0;
        t.valid        = 1'b1;
        t.sdid         = sd;
        t.spa          = spa;
        t.access       = acc;
        t.format_error = NO_ERROR;
        t.walking      = MPT_WALKING_L2;
        t.mpte         = 32'hdead_beef;
        t.mpte_ptr     = 16'h1234;
        return t;
    endfunction

    // Expected output given the hand-derived hit value
    function automatic mptw_transaction_t exp_of(input mptw_transaction_t t, input logic h);
        mptw_transaction_t r;
        r           = t;
        r.completed = h;
        r.plb_hit   = h;
        r.mpte      = '0;
        r.mpte_ptr  = '0;
        if (t.format_error != NO_ERROR || h) r.walking = MPT_WALKING_SKIP;
        return r;
    endfunction

    // Scoreboard: compare every delivered output against the queue head
    always @(negedge clk) begin
        if (!rst_i && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output got=%0h", m_data);
            end else begin
                chk("out_txn", 128'(m_data), 128'(exp_q.pop_front()));
            end
        end
    end

    // Entered and left at posedge+1
    task automatic send(input mptw_transaction_t t, input logic h);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = t;
        @(negedge clk);
        while (!s_ready) begin
            n++;
            if (n > 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout got=ready0 exp=ready1");
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        exp_q.push_back(exp_of(t, h));
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic refill(input logic [5:0] sd, input logic [43:0] ppn, input logic [2:0] p);
        refill_valid = 1'b1; refill_sdid = sd; refill_ppn = ppn; refill_perm = p;
        @(posedge clk); #1;
        refill_valid = 1'b0;
    endtask

    task automatic do_flush(input logic sv, input logic [5:0] sd);
        flush = 1'b1; flush_sv = sv; flush_sdid = sd;
        @(negedge clk);
        chk("flush_blocks_ready", 128'(s_ready), 128'(0));
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue_empty", 128'(exp_q.size()), 128'(0));
    endtask

    function automatic logic [55:0] pg(input logic [43:0] ppn);
        return {ppn, 12'h5a5};
    endfunction

    typedef struct {
        mptw_transaction_t t;
        logic              hit;
    } vec_t;

    vec_t vecs[8];

    initial begin
        mptw_transaction_t a, b, t;

        // Table of lookups run after refill {sdid1, ppn 0x80001, rw}
        vecs[0] = '{mk(6'd1, 56'h8000_1000, PLB_PERM_R), 1'b1};
        vecs[1] = '{mk(6'd1, 56'h8000_1fff, PLB_PERM_R | PLB_PERM_W), 1'b1};
        vecs[2] = '{mk(6'd1, 56'h8000_1000, PLB_PERM_X), 1'b0};
        vecs[3] = '{mk(6'd2, 56'h8000_1000, PLB_PERM_R), 1'b0};
        vecs[4] = '{mk(6'd1, 56'h8000_2000, PLB_PERM_R), 1'b0};
        vecs[5] = '{mk(6'd1, 56'h8000_1000, PLB_PERM_R), 1'b0};
        vecs[5].t.format_error = ERR_ALIGN;
        vecs[6] = '{mk(6'd1, 56'h8000_1000, PLB_PERM_R), 1'b0};
        vecs[6].t.valid = 1'b0;
        vecs[7] = '{mk(6'd1, 56'h8000_1000, 3'b000), 1'b1};

        rst_i = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        refill_valid = 1'b0; refill_sdid = '0; refill_ppn = '0; refill_perm = '0;
        flush = 1'b0; flush_sv = 1'b0; flush_sdid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_master_valid", 128'(m_valid), 128'(0));
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_slave_ready", 128'(s_ready), 128'(1));
`ifdef PLB_STATS_EN
        chk("reset_stat_hits", 128'(stat_hits), 128'(0));
`endif
        @(posedge clk); #1;

        // 1: cold miss, one-cycle latency
        send(mk(6'd1, 56'h8000_1000, PLB_PERM_R), 1'b0);
        chk("t1_latency_valid", 128'(m_valid), 128'(1));
        drain();

        // 2: refill then table of lookups back to back
        refill(6'd1, 44'h80001, PLB_PERM_R | PLB_PERM_W);
        for (int i = 0; i < 8; i++) send(vecs[i].t, vecs[i].hit);
        drain();
        // refill and lookup in the same cycle: lookup sees old contents
        t = mk(6'd7, pg(44'h777), PLB_PERM_R);
        refill_valid = 1'b1; refill_sdid = 6'd7; refill_ppn = 44'h777; refill_perm = PLB_PERM_R;
        send(t, 1'b0);
        refill_valid = 1'b0;
        send(t, 1'b1);
        drain();

        // 3: fill, evict entry 0, in-place perm update, next eviction hits slot 1
        do_flush(1'b0, 6'd0);
        for (int i = 0; i < 8; i++) refill(6'd3, 44'h100 + 44'(i), PLB_PERM_R);
        refill(6'd3, 44'h200, PLB_PERM_R);
        send(mk(6'd3, pg(44'h100), PLB_PERM_R), 1'b0);
        send(mk(6'd3, pg(44'h200), PLB_PERM_R), 1'b1);
        send(mk(6'd3, pg(44'h101), PLB_PERM_R), 1'b1);
        send(mk(6'd3, pg(44'h107), PLB_PERM_R), 1'b1);
        refill(6'd3, 44'h101, PLB_PERM_X);
        send(mk(6'd3, pg(44'h101), PLB_PERM_X), 1'b1);
        send(mk(6'd3, pg(44'h101), PLB_PERM_R), 1'b0);
        send(mk(6'd3, pg(44'h102), PLB_PERM_R), 1'b1);
        refill(6'd3, 44'h201, PLB_PERM_R);
        send(mk(6'd3, pg(44'h101), PLB_PERM_X), 1'b0);
        send(mk(6'd3, pg(44'h102), PLB_PERM_R), 1'b1);
        send(mk(6'd3, pg(44'h201), PLB_PERM_R), 1'b1);
        drain();

        // 4: flush by SDID, flush all, flush beats refill
        do_flush(1'b0, 6'd0);
        refill(6'd1, 44'h10, PLB_PERM_R);
        refill(6'd2, 44'h10, PLB_PERM_R);
        do_flush(1'b1, 6'd1);
        send(mk(6'd1, pg(44'h10), PLB_PERM_R), 1'b0);
        send(mk(6'd2, pg(44'h10), PLB_PERM_R), 1'b1);
        do_flush(1'b0, 6'd0);
        send(mk(6'd2, pg(44'h10), PLB_PERM_R), 1'b0);
        refill_valid = 1'b1; refill_sdid = 6'd4; refill_ppn = 44'h44; refill_perm = PLB_PERM_R;
        do_flush(1'b0, 6'd0);
        refill_valid = 1'b0;
        send(mk(6'd4, pg(44'h44), PLB_PERM_R), 1'b0);
        drain();

        // 5: backpressure for 5 cycles, held data, ordered delivery
        a = mk(6'd9, pg(44'hA), PLB_PERM_R);
        b = mk(6'd9, pg(44'hB), PLB_PERM_W);
        m_ready = 1'b0;
        send(a, 1'b0);
        s_valid = 1'b1; s_data = b;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_slave_ready", 128'(s_ready), 128'(0));
            chk("stall_master_valid", 128'(m_valid), 128'(1));
            chk("stall_held_data", 128'(m_data), 128'(exp_of(a, 1'b0)));
        end
        @(posedge clk); #1;
        exp_q.push_back(exp_of(b, 1'b0));
        m_ready = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        drain();

        // Reset with a stalled output discards it
        m_ready = 1'b0;
        send(mk(6'd1, pg(44'h1), PLB_PERM_R), 1'b0);
        @(negedge clk);
        chk("pre_reset_valid", 128'(m_valid), 128'(1));
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_reset_valid", 128'(m_valid), 128'(0));
        @(posedge clk); #1;
        m_ready = 1'b1;

`ifdef PLB_STATS_EN
        // 6: 3 hits, 2 misses, 1 malformed (not counted)
        refill(6'd5, 44'h5, PLB_PERM_R);
        for (int i = 0; i < 3; i++) send(mk(6'd5, pg(44'h5), PLB_PERM_R), 1'b1);
        for (int i = 0; i < 2; i++) send(mk(6'd5, pg(44'h6), PLB_PERM_R), 1'b0);
        t = mk(6'd5, pg(44'h5), PLB_PERM_R);
        t.format_error = ERR_RANGE;
        send(t, 1'b0);
        drain();
        chk("stat_hits", 128'(stat_hits), 128'(3));
        chk("stat_misses", 128'(stat_misses), 128'(2));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
